// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_port_arbiter
// Description : Shares the single data-memory port between the MEM stage and
//               a debug/loader requester. The CPU has fixed priority; a
//               starvation counter forces a debug grant after MAX_WAIT lost
//               cycles, and the CPU is stalled for that one cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int MAX_WAIT   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_rd,
  input  logic                  cpu_wr,
  input  logic [DM_ADDRESS-1:0] cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  input  logic [2:0]            cpu_funct3,
  output logic [DATA_W-1:0]     cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [DM_ADDRESS-1:0] dbg_addr,
  input  logic [DATA_W-1:0]     dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_W-1:0]     dbg_rdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int                c_CNT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [c_CNT_W-1:0] c_WAIT_MAX = c_CNT_W'(MAX_WAIT);
  localparam logic [2:0]        c_F3_WORD  = 3'b010;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_DRESP = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_CNT_W-1:0] r_wait_cnt;
  logic               w_cpu_act;
  logic               w_force;
  logic               w_dbg_sel;
  logic               w_dbg_rd_gnt;

  // Grant decision: debug wins when the CPU is idle or when it has waited too long
  always_comb begin
    w_cpu_act    = cpu_rd | cpu_wr;
    w_force      = dbg_req && (r_wait_cnt == c_WAIT_MAX);
    w_dbg_sel    = dbg_req && (!w_cpu_act || w_force);
    w_dbg_rd_gnt = w_dbg_sel && !dbg_we;
    dbg_gnt      = w_dbg_sel;
    cpu_stall    = w_cpu_act && w_dbg_sel;
  end

  // Memory port mux; CPU load data is zeroed in cycles the debug side owns the port
  always_comb begin
    mem_rd     = cpu_rd;
    mem_wr     = cpu_wr;
    mem_addr   = cpu_addr;
    mem_wdata  = cpu_wdata;
    mem_funct3 = cpu_funct3;
    cpu_rdata  = mem_rdata;
    if (w_dbg_sel) begin
      mem_rd     = !dbg_we;
      mem_wr     = dbg_we;
      mem_addr   = dbg_addr;
      mem_wdata  = dbg_wdata;
      mem_funct3 = c_F3_WORD;
      cpu_rdata  = '0;
    end
  end

  // Starvation counter: counts consecutive lost cycles, saturating as a safety net
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait_cnt <= '0;
    end else if (!dbg_req || dbg_gnt) begin
      r_wait_cnt <= '0;
    end else if (r_wait_cnt != c_WAIT_MAX) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // Response FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: every read grant (including back-to-back ones) lands in DRESP
  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE:  w_state_nxt = w_dbg_rd_gnt ? S_DRESP : S_IDLE;
      S_DRESP: w_state_nxt = w_dbg_rd_gnt ? S_DRESP : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Read data is captured from the combinational memory read at the grant edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dbg_rdata <= '0;
    end else if (w_dbg_rd_gnt) begin
      dbg_rdata <= mem_rdata;
    end
  end

  assign dbg_rvalid = (r_state == S_DRESP);

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_port_arbiter
// Description : Directed self-checking bench for dmem_port_arbiter with a
//               small word-addressed memory model behind the port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_port_arbiter;

  localparam int DATA_W     = 32;
  localparam int DM_ADDRESS = 9;
  localparam int MAX_WAIT   = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  cpu_rd, cpu_wr;
  logic [DM_ADDRESS-1:0] cpu_addr;
  logic [DATA_W-1:0]     cpu_wdata;
  logic [2:0]            cpu_funct3;
  logic [DATA_W-1:0]     cpu_rdata;
  logic                  cpu_stall;
  logic                  dbg_req, dbg_we;
  logic [DM_ADDRESS-1:0] dbg_addr;
  logic [DATA_W-1:0]     dbg_wdata;
  logic                  dbg_gnt, dbg_rvalid;
  logic [DATA_W-1:0]     dbg_rdata;
  logic                  mem_rd, mem_wr;
  logic [DM_ADDRESS-1:0] mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [2:0]            mem_funct3;
  logic [DATA_W-1:0]     mem_rdata;

  logic [DATA_W-1:0]     mem [0:127];

  int n_checks = 0;
  int n_fails  = 0;

  dmem_port_arbiter #(
    .DATA_W(DATA_W), .DM_ADDRESS(DM_ADDRESS), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_funct3(cpu_funct3),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_funct3(mem_funct3), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Word memory model: combinational read, write on posedge
  assign mem_rdata = mem[mem_addr[8:2]];
  always @(posedge clk) begin
    if (mem_wr) mem[mem_addr[8:2]] <= mem_wdata;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = '0;
    reset = 1'b1;
    cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wdata = '0; cpu_funct3 = 3'b010;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
    step(); step();
    check_val("rst_rvalid", 32'(dbg_rvalid), 32'd0);
    check_val("rst_rdata", dbg_rdata, 32'h0);
    check_val("rst_wait", 32'(dut.r_wait_cnt), 32'd0);
    check_val("rst_gnt", 32'(dbg_gnt), 32'd0);
    check_val("idle_memrw", {30'd0, mem_rd, mem_wr}, 32'd0);
    reset = 1'b0;
    step();

    // CPU only: store then load
    cpu_wr = 1; cpu_addr = 9'h010; cpu_wdata = 32'hDEADBEEF;
    #1;
    check_val("cpu_wr_stall", 32'(cpu_stall), 32'd0);
    check_val("cpu_wr_memwr", 32'(mem_wr), 32'd1);
    check_val("cpu_wr_gnt", 32'(dbg_gnt), 32'd0);
    step();
    cpu_wr = 0; cpu_rd = 1;
    #1;
    check_val("cpu_rd_data", cpu_rdata, 32'hDEADBEEF);
    check_val("cpu_rd_stall", 32'(cpu_stall), 32'd0);
    step();
    cpu_rd = 0;

    // Debug only: write then back-to-back read
    dbg_req = 1; dbg_we = 1; dbg_addr = 9'h020; dbg_wdata = 32'h12345678;
    #1;
    check_val("dbg_wr_gnt", 32'(dbg_gnt), 32'd1);
    check_val("dbg_wr_memwr", 32'(mem_wr), 32'd1);
    check_val("dbg_wr_f3", 32'(mem_funct3), 32'd2);
    step();
    dbg_we = 0;
    #1;
    check_val("dbg_wr_norvalid", 32'(dbg_rvalid), 32'd0);
    check_val("dbg_rd_gnt", 32'(dbg_gnt), 32'd1);
    check_val("dbg_rd_memrd", 32'(mem_rd), 32'd1);
    step();
    dbg_req = 0;
    #1;
    check_val("dbg_rvalid", 32'(dbg_rvalid), 32'd1);
    check_val("dbg_rdata", dbg_rdata, 32'h12345678);
    step();
    check_val("dbg_rvalid_1cyc", 32'(dbg_rvalid), 32'd0);

    // Async reset mid-cycle drops a pending response
    dbg_req = 1;
    step();
    dbg_req = 0;
    #1;
    check_val("pre_rst_rvalid", 32'(dbg_rvalid), 32'd1);
    reset = 1'b1;
    #1;
    check_val("async_rst_rvalid", 32'(dbg_rvalid), 32'd0);
    check_val("async_rst_rdata", dbg_rdata, 32'h0);
    #1;
    reset = 1'b0;
    step();

    // Starvation: CPU busy every cycle, debug read pending
    cpu_rd = 1; cpu_addr = 9'h010; dbg_req = 1; dbg_we = 0; dbg_addr = 9'h020;
    for (int i = 0; i < MAX_WAIT; i++) begin
      #1;
      check_val("starve_gnt", 32'(dbg_gnt), 32'd0);
      check_val("starve_stall", 32'(cpu_stall), 32'd0);
      check_val("starve_wait", 32'(dut.r_wait_cnt), 32'(i));
      check_val("starve_cpu_data", cpu_rdata, 32'hDEADBEEF);
      step();
    end
    #1;
    check_val("force_wait", 32'(dut.r_wait_cnt), 32'd8);
    check_val("force_gnt", 32'(dbg_gnt), 32'd1);
    check_val("force_stall", 32'(cpu_stall), 32'd1);
    check_val("force_addr", 32'(mem_addr), 32'h20);
    check_val("force_cpu_data", cpu_rdata, 32'h0);
    step();
    dbg_req = 0;
    #1;
    check_val("after_force_stall", 32'(cpu_stall), 32'd0);
    check_val("after_force_data", cpu_rdata, 32'hDEADBEEF);
    check_val("after_force_rvalid", 32'(dbg_rvalid), 32'd1);
    check_val("after_force_rdata", dbg_rdata, 32'h12345678);
    check_val("after_force_wait", 32'(dut.r_wait_cnt), 32'd0);
    step();

    // Saturation: hold dbg_req for 12 cycles against a busy CPU
    dbg_req = 1;
    for (int i = 0; i < 12; i++) begin
      #1;
      check_val("sat_bound", 32'(dut.r_wait_cnt <= 4'(MAX_WAIT)), 32'd1);
      step();
    end
    check_val("sat_wait_wrap", 32'(dut.r_wait_cnt), 32'd3);
    #1;
    reset = 1'b1;
    #1;
    check_val("async_rst_wait", 32'(dut.r_wait_cnt), 32'd0);
    reset = 1'b0;
    step(); step();
    check_val("wait_after_rst", 32'(dut.r_wait_cnt), 32'd2);
    dbg_req = 0;
    step();
    check_val("drop_req_wait", 32'(dut.r_wait_cnt), 32'd0);
    cpu_rd = 0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
